// File: rtl/fire_sched_pkg.sv
// Shared types and constants for the fire scheduler.
// Optional trace outputs of fire_scheduler are enabled by defining FIRE_SCHED_TRACE_EN.
package fire_sched_pkg;

    // Selection policy for the next signal to fire
    typedef enum logic [1:0] {
        MODE_RR   = 2'd0,
        MODE_LFSR = 2'd1,
        MODE_EXT  = 2'd2
    } mode_e;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left: feedback from bits 15,13,12,10
    localparam int unsigned          LFSR_W    = 16;
    localparam logic [LFSR_W-1:0]    LFSR_TAPS = 16'hB400;

    // Quiescence watchdog states
    typedef enum logic {
        STALL_RUN      = 1'b0,
        STALL_DEADLOCK = 1'b1
    } stall_state_e;

    // Width of a fire index able to hold 0..nsig
    function automatic int unsigned fire_w(input int unsigned nsig);
        return $clog2(nsig + 1);
    endfunction

endpackage

// File: rtl/fire_rr_pick.sv
// Wrap-around priority picker: first set request at or after start_i, wrapping to 0.
module fire_rr_pick
    import fire_sched_pkg::*;
#(
    parameter int unsigned NSIG  = 8,
    parameter int unsigned IDX_W = fire_w(NSIG)
) (
    input  logic [NSIG-1:0]  req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [2*NSIG-1:0] dbl;
    logic [NSIG-1:0]   rot;

    // Rotate requests so that position start_i lands on bit 0
    assign dbl = {req_i, req_i} >> start_i;
    assign rot = dbl[NSIG-1:0];

    // Lowest rotated bit wins; scan high to low so the last hit is the nearest one
    always_comb begin
        int unsigned pos;
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        for (int unsigned i = NSIG; i > 0; i--) begin
            if (rot[i-1]) begin
                valid_o = 1'b1;
                pos     = 32'(start_i) + i - 1;
                if (pos >= NSIG) begin
                    pos = pos - NSIG;
                end
                idx_o = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/fire_scheduler.sv
// Single-fire state capture: commits at most one excited signal per enabled cycle,
// with round-robin / LFSR / external selection, deadlock watchdog and step counter.
// Define FIRE_SCHED_TRACE_EN to add registered trace ports for each commit.
module fire_scheduler
    import fire_sched_pkg::*;
#(
    parameter int unsigned      NSIG        = 8,
    parameter logic [NSIG-1:0]  INIT        = '0,
    parameter int unsigned      MODE        = 0,
    parameter logic [15:0]      LFSR_SEED   = 16'hACE1,
    parameter int unsigned      STALL_LIMIT = 16,
    localparam int unsigned     FIRE_W      = fire_w(NSIG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [FIRE_W-1:0] fire_ext,
    input  logic [NSIG-1:0]   precap,
    output logic [NSIG-1:0]   state,
    output logic [NSIG-1:0]   excited,
    output logic              fire_valid,
    output logic [FIRE_W-1:0] fire_idx,
    output logic              fire_nop,
    output logic              deadlock,
    output logic [31:0]       step_count
`ifdef FIRE_SCHED_TRACE_EN
    ,
    output logic              trace_valid,
    output logic [FIRE_W-1:0] trace_idx,
    output logic              trace_val,
    output logic [31:0]       trace_step
`endif
);

    localparam int unsigned STALL_W  = $clog2(STALL_LIMIT + 1);
    localparam mode_e       MODE_SEL = mode_e'(MODE);

    logic [NSIG-1:0]   state_q, state_d;
    logic [FIRE_W-1:0] ptr_q, ptr_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              fire_valid_q, fire_valid_d;
    logic [FIRE_W-1:0] fire_idx_q, fire_idx_d;
    logic              fire_nop_q, fire_nop_d;
    logic [31:0]       step_q, step_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    stall_state_e      st_q, st_d;

    logic              any_exc;
    logic [FIRE_W-1:0] scan_start;
    logic              pick_valid;
    logic [FIRE_W-1:0] pick_idx;
    logic              ext_hit;
    logic              commit;
    logic [FIRE_W-1:0] commit_idx;

    assign excited    = precap ^ state_q;
    assign any_exc    = |excited;
    assign state      = state_q;
    assign fire_valid = fire_valid_q;
    assign fire_idx   = fire_idx_q;
    assign fire_nop   = fire_nop_q;
    assign step_count = step_q;
    assign deadlock   = (st_q == STALL_DEADLOCK);

    // Scan start: rotating pointer, or the current LFSR value reduced modulo NSIG
    always_comb begin
        if (MODE_SEL == MODE_LFSR) begin
            scan_start = FIRE_W'(lfsr_q % LFSR_W'(NSIG));
        end else begin
            scan_start = ptr_q;
        end
    end

    fire_rr_pick #(
        .NSIG  (NSIG),
        .IDX_W (FIRE_W)
    ) u_pick (
        .req_i   (excited),
        .start_i (scan_start),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // External index hits only when in range and excited; out-of-range never matches
    always_comb begin
        ext_hit = 1'b0;
        for (int unsigned i = 0; i < NSIG; i++) begin
            if (fire_ext == FIRE_W'(i) && excited[i]) begin
                ext_hit = 1'b1;
            end
        end
    end

    // Final commit decision for this cycle
    always_comb begin
        if (MODE_SEL == MODE_EXT) begin
            commit     = en & ext_hit;
            commit_idx = fire_ext;
        end else begin
            commit     = en & pick_valid;
            commit_idx = pick_idx;
        end
    end

    // Next-state for signal bits, pointer, LFSR, fire flags and step counter
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lfsr_d       = lfsr_q;
        fire_valid_d = 1'b0;
        fire_idx_d   = '0;
        fire_nop_d   = 1'b0;
        step_d       = step_q;
        if (en) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
            if (commit) begin
                for (int unsigned i = 0; i < NSIG; i++) begin
                    if (commit_idx == FIRE_W'(i)) begin
                        state_d[i] = precap[i];
                    end
                end
                fire_valid_d = 1'b1;
                fire_idx_d   = commit_idx;
                if (step_q != '1) begin
                    step_d = step_q + 32'd1;
                end
                if (MODE_SEL == MODE_RR) begin
                    ptr_d = (commit_idx == FIRE_W'(NSIG - 1)) ? '0 : commit_idx + 1'b1;
                end
            end else if (MODE_SEL == MODE_EXT) begin
                fire_nop_d = 1'b1;
            end
        end
    end

    // Stall watchdog next-state: count quiescent enabled cycles, any excitation restarts
    always_comb begin
        stall_d = stall_q;
        st_d    = st_q;
        if (en) begin
            case (st_q)
                STALL_RUN: begin
                    if (any_exc) begin
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q + 1'b1;
                        if (stall_d == STALL_W'(STALL_LIMIT)) begin
                            st_d = STALL_DEADLOCK;
                        end
                    end
                end
                STALL_DEADLOCK: begin
                    if (any_exc) begin
                        stall_d = '0;
                        st_d    = STALL_RUN;
                    end
                end
            endcase
        end
    end

    // Stall watchdog state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= STALL_RUN;
            stall_q <= '0;
        end else begin
            st_q    <= st_d;
            stall_q <= stall_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= INIT;
            ptr_q        <= '0;
            lfsr_q       <= LFSR_SEED;
            fire_valid_q <= 1'b0;
            fire_idx_q   <= '0;
            fire_nop_q   <= 1'b0;
            step_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lfsr_q       <= lfsr_d;
            fire_valid_q <= fire_valid_d;
            fire_idx_q   <= fire_idx_d;
            fire_nop_q   <= fire_nop_d;
            step_q       <= step_d;
        end
    end

`ifdef FIRE_SCHED_TRACE_EN
    logic              trace_valid_q;
    logic [FIRE_W-1:0] trace_idx_q;
    logic              trace_val_q;
    logic [31:0]       trace_step_q;
    logic              trace_val_d;

    // New value of the committed bit
    always_comb begin
        trace_val_d = 1'b0;
        for (int unsigned i = 0; i < NSIG; i++) begin
            if (commit_idx == FIRE_W'(i)) begin
                trace_val_d = precap[i];
            end
        end
    end

    // Trace registers capture each commit; payload holds between commits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_valid_q <= 1'b0;
            trace_idx_q   <= '0;
            trace_val_q   <= 1'b0;
            trace_step_q  <= '0;
        end else begin
            trace_valid_q <= commit;
            if (commit) begin
                trace_idx_q  <= commit_idx;
                trace_val_q  <= trace_val_d;
                trace_step_q <= step_d;
            end
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_idx   = trace_idx_q;
    assign trace_val   = trace_val_q;
    assign trace_step  = trace_step_q;
`endif

endmodule

// File: tb/tb_fire_scheduler.sv
// Bench for fire_scheduler: three NSIG=4 instances (round-robin, LFSR, external fire).
module tb_fire_scheduler;

    localparam int unsigned NS = 4;

    typedef struct {
        logic        en;
        logic [3:0]  pre;
        logic [2:0]  fx;
        logic [3:0]  st;
        logic        fv;
        logic [2:0]  idx;
        logic        nop;
        logic        dl;
        int unsigned steps;
    } vec_t;

    typedef struct packed {
        logic       en;
        logic [3:0] pre;
    } rec_t;

    logic clk;
    logic rst_n;

    logic        en_a   [3];
    logic [3:0]  pre_a  [3];
    logic [2:0]  fx_a   [3];
    logic [3:0]  st_a   [3];
    logic [3:0]  exc_a  [3];
    logic        fv_a   [3];
    logic [2:0]  fi_a   [3];
    logic        nop_a  [3];
    logic        dl_a   [3];
    logic [31:0] sc_a   [3];

    int unsigned tests;
    int unsigned fails;

    // reference model state
    logic [3:0]  m_init  [3];
    logic [3:0]  m_state [3];
    int unsigned m_stall [3];
    logic        m_fv    [3];
    int unsigned m_fi    [3];
    logic        m_nop   [3];
    int unsigned m_steps [3];
    int unsigned m_ptr;
    logic [15:0] m_lfsr;

    vec_t tbl_rr [15];
    vec_t tbl_ex [6];
    rec_t lf_rec [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fire_scheduler #(.NSIG(4), .INIT(4'b0000), .MODE(0), .LFSR_SEED(16'hACE1), .STALL_LIMIT(4)) u_rr (
        .clk(clk), .reset(rst_n), .en(en_a[0]), .fire_ext(fx_a[0]), .precap(pre_a[0]),
        .state(st_a[0]), .excited(exc_a[0]), .fire_valid(fv_a[0]), .fire_idx(fi_a[0]),
        .fire_nop(nop_a[0]), .deadlock(dl_a[0]), .step_count(sc_a[0]));

    fire_scheduler #(.NSIG(4), .INIT(4'b1010), .MODE(1), .LFSR_SEED(16'hACE1), .STALL_LIMIT(4)) u_lf (
        .clk(clk), .reset(rst_n), .en(en_a[1]), .fire_ext(fx_a[1]), .precap(pre_a[1]),
        .state(st_a[1]), .excited(exc_a[1]), .fire_valid(fv_a[1]), .fire_idx(fi_a[1]),
        .fire_nop(nop_a[1]), .deadlock(dl_a[1]), .step_count(sc_a[1]));

    fire_scheduler #(.NSIG(4), .INIT(4'b0000), .MODE(2), .LFSR_SEED(16'hACE1), .STALL_LIMIT(4)) u_ex (
        .clk(clk), .reset(rst_n), .en(en_a[2]), .fire_ext(fx_a[2]), .precap(pre_a[2]),
        .state(st_a[2]), .excited(exc_a[2]), .fire_valid(fv_a[2]), .fire_idx(fi_a[2]),
        .fire_nop(nop_a[2]), .deadlock(dl_a[2]), .step_count(sc_a[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [3:0] pre, input logic [2:0] fx,
                                input logic [3:0] st, input logic fv, input logic [2:0] idx,
                                input logic nop, input logic dl, input int unsigned steps);
        vec_t v;
        v.en = en; v.pre = pre; v.fx = fx; v.st = st; v.fv = fv;
        v.idx = idx; v.nop = nop; v.dl = dl; v.steps = steps;
        return v;
    endfunction

    task automatic apply_vec(input int d, input vec_t v, input string tag, input int row);
        @(negedge clk);
        en_a[d]  = v.en;
        pre_a[d] = v.pre;
        fx_a[d]  = v.fx;
        @(posedge clk);
        #1;
        check($sformatf("%s%0d state", tag, row), 32'(st_a[d]), 32'(v.st));
        check($sformatf("%s%0d fire_valid", tag, row), 32'(fv_a[d]), 32'(v.fv));
        check($sformatf("%s%0d fire_idx", tag, row), 32'(fi_a[d]), 32'(v.idx));
        check($sformatf("%s%0d fire_nop", tag, row), 32'(nop_a[d]), 32'(v.nop));
        check($sformatf("%s%0d deadlock", tag, row), 32'(dl_a[d]), 32'(v.dl));
        check($sformatf("%s%0d step_count", tag, row), sc_a[d], v.steps);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_state[d] = m_init[d];
            m_stall[d] = 0;
            m_fv[d]    = 1'b0;
            m_fi[d]    = 0;
            m_nop[d]   = 1'b0;
            m_steps[d] = 0;
        end
        m_ptr  = 0;
        m_lfsr = 16'hACE1;
    endtask

    // One enabled/disabled cycle of the behavioural model for instance d (0=RR, 1=LFSR, 2=EXT)
    task automatic model_step(input int d);
        logic [3:0] exc;
        int         k;
        int         start;
        if (!en_a[d]) begin
            m_fv[d]  = 1'b0;
            m_fi[d]  = 0;
            m_nop[d] = 1'b0;
            return;
        end
        exc = pre_a[d] ^ m_state[d];
        k   = -1;
        if (d == 2) begin
            if (int'(fx_a[d]) < NS && exc[fx_a[d]]) k = int'(fx_a[d]);
        end else begin
            start = (d == 0) ? int'(m_ptr) : int'(m_lfsr) % NS;
            for (int off = 0; off < NS; off++) begin
                if (exc[(start + off) % NS]) begin
                    k = (start + off) % NS;
                    break;
                end
            end
        end
        if (d == 1) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (k >= 0) begin
            m_state[d][k] = pre_a[d][k];
            m_fv[d]    = 1'b1;
            m_fi[d]    = k;
            m_nop[d]   = 1'b0;
            m_steps[d] = m_steps[d] + 1;
            if (d == 0) m_ptr = (k + 1) % NS;
        end else begin
            m_fv[d]  = 1'b0;
            m_fi[d]  = 0;
            m_nop[d] = (d == 2);
        end
        if (exc != 4'h0) m_stall[d] = 0;
        else if (m_stall[d] < 4) m_stall[d] = m_stall[d] + 1;
    endtask

    task automatic check_dut(input int d, input int cyc);
        check($sformatf("d%0d c%0d state", d, cyc), 32'(st_a[d]), 32'(m_state[d]));
        check($sformatf("d%0d c%0d excited", d, cyc), 32'(exc_a[d]), 32'(pre_a[d] ^ m_state[d]));
        check($sformatf("d%0d c%0d fire_valid", d, cyc), 32'(fv_a[d]), 32'(m_fv[d]));
        check($sformatf("d%0d c%0d fire_idx", d, cyc), 32'(fi_a[d]), m_fi[d]);
        check($sformatf("d%0d c%0d fire_nop", d, cyc), 32'(nop_a[d]), 32'(m_nop[d]));
        check($sformatf("d%0d c%0d deadlock", d, cyc), 32'(dl_a[d]), 32'(m_stall[d] == 4));
        check($sformatf("d%0d c%0d step_count", d, cyc), sc_a[d], m_steps[d]);
    endtask

    initial begin
        logic [3:0] mask;
        tests = 0;
        fails = 0;
        m_init[0] = 4'b0000;
        m_init[1] = 4'b1010;
        m_init[2] = 4'b0000;
        for (int d = 0; d < 3; d++) begin
            en_a[d] = 1'b0; pre_a[d] = 4'h0; fx_a[d] = 3'd0;
        end

        // round-robin sequence: fill, wrap, deadlock, recovery, pointer-order checks
        tbl_rr[0]  = mk(1'b1, 4'b1111, 3'd0, 4'b0001, 1'b1, 3'd0, 1'b0, 1'b0, 1);
        tbl_rr[1]  = mk(1'b1, 4'b1111, 3'd0, 4'b0011, 1'b1, 3'd1, 1'b0, 1'b0, 2);
        tbl_rr[2]  = mk(1'b1, 4'b1111, 3'd0, 4'b0111, 1'b1, 3'd2, 1'b0, 1'b0, 3);
        tbl_rr[3]  = mk(1'b1, 4'b1111, 3'd0, 4'b1111, 1'b1, 3'd3, 1'b0, 1'b0, 4);
        tbl_rr[4]  = mk(1'b1, 4'b1101, 3'd0, 4'b1101, 1'b1, 3'd1, 1'b0, 1'b0, 5);
        tbl_rr[5]  = mk(1'b1, 4'b1101, 3'd0, 4'b1101, 1'b0, 3'd0, 1'b0, 1'b0, 5);
        tbl_rr[6]  = mk(1'b1, 4'b1101, 3'd0, 4'b1101, 1'b0, 3'd0, 1'b0, 1'b0, 5);
        tbl_rr[7]  = mk(1'b1, 4'b1101, 3'd0, 4'b1101, 1'b0, 3'd0, 1'b0, 1'b0, 5);
        tbl_rr[8]  = mk(1'b1, 4'b1101, 3'd0, 4'b1101, 1'b0, 3'd0, 1'b0, 1'b1, 5);
        tbl_rr[9]  = mk(1'b0, 4'b1101, 3'd0, 4'b1101, 1'b0, 3'd0, 1'b0, 1'b1, 5);
        tbl_rr[10] = mk(1'b1, 4'b1000, 3'd0, 4'b1001, 1'b1, 3'd2, 1'b0, 1'b0, 6);
        tbl_rr[11] = mk(1'b1, 4'b1000, 3'd0, 4'b1000, 1'b1, 3'd0, 1'b0, 1'b0, 7);
        tbl_rr[12] = mk(1'b0, 4'b0111, 3'd0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0, 7);
        tbl_rr[13] = mk(1'b1, 4'b0111, 3'd0, 4'b1010, 1'b1, 3'd1, 1'b0, 1'b0, 8);
        tbl_rr[14] = mk(1'b1, 4'b0111, 3'd0, 4'b1110, 1'b1, 3'd2, 1'b0, 1'b0, 9);

        // external-fire sequence: out-of-range, boundary, non-excited, valid commit
        tbl_ex[0] = mk(1'b1, 4'b0100, 3'd5, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 0);
        tbl_ex[1] = mk(1'b1, 4'b0100, 3'd4, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 0);
        tbl_ex[2] = mk(1'b1, 4'b0100, 3'd1, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 0);
        tbl_ex[3] = mk(1'b1, 4'b0100, 3'd2, 4'b0100, 1'b1, 3'd2, 1'b0, 1'b0, 1);
        tbl_ex[4] = mk(1'b0, 4'b0100, 3'd5, 4'b0100, 1'b0, 3'd0, 1'b0, 1'b0, 1);
        tbl_ex[5] = mk(1'b1, 4'b0101, 3'd0, 4'b0101, 1'b1, 3'd0, 1'b0, 1'b0, 2);

        // reset state while reset is held
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int d = 0; d < 3; d++) check_dut(d, -1);

        // released, disabled: INIT held
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("init en0 state", 32'(st_a[1]), 32'h0000000A);
        check("init en0 step_count", sc_a[1], 32'd0);
        check("init en0 deadlock", 32'(dl_a[1]), 32'd0);
        check("init en0 fire_valid", 32'(fv_a[1]), 32'd0);

        for (int r = 0; r < 15; r++) apply_vec(0, tbl_rr[r], "rr", r);
        en_a[0] = 1'b0;
        for (int r = 0; r < 6; r++) apply_vec(2, tbl_ex[r], "ex", r);
        en_a[2] = 1'b0;

        // randomized run against the model, with mid-cycle resets and an LFSR replay
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                mask     = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom);
                en_a[d]  = ($urandom_range(0, 7) != 0);
                pre_a[d] = m_state[d] ^ mask;
                fx_a[d]  = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            end
            if (i < 50) lf_rec.push_back('{en_a[1], pre_a[1]});
            if (i >= 100 && i < 150) begin
                en_a[1]  = lf_rec[i-100].en;
                pre_a[1] = lf_rec[i-100].pre;
            end
            if (i == 0 || i == 70 || i == 100) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                for (int d = 0; d < 3; d++) check_dut(d, 1000 + i);
                #1 rst_n = 1'b1;
            end
            for (int d = 0; d < 3; d++) model_step(d);
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) check_dut(d, i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
